// File: rtl/noc_inject_arbiter_if.sv
// Handshake bundle between local packet sources and the injection arbiter.
// The master is the source/router side; the slave is the arbiter.
interface noc_inject_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_VC  = 4,
  parameter int FLIT_W  = 34
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*FLIT_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_VC-1:0]         out_ready;
  logic [NUM_VC-1:0]         out_valid;
  logic [FLIT_W-1:0]         out_flit;
  logic [NUM_VC-1:0]         vc_busy;
  logic                      err;

  modport master (
    output req_valid, req_flit, out_ready,
    input  req_ready, out_valid, out_flit, vc_busy, err
  );

  modport slave (
    input  req_valid, req_flit, out_ready,
    output req_ready, out_valid, out_flit, vc_busy, err
  );
endinterface

// File: rtl/noc_inject_arbiter.sv
// Wormhole injection arbiter: binds requesters to free VCs on header flits and
// round-robin switches one flit per cycle onto the shared router input link.
module noc_inject_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_VC  = 4,
  parameter int FLIT_W  = 34
) (
  input  logic             noc_clk,
  input  logic             noc_rst,
  noc_inject_arbiter_if.slave bus
);
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  logic [RW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] bound_q, bound_d;
  logic [VW-1:0]      req_vc_q [NUM_REQ];
  logic [VW-1:0]      req_vc_d [NUM_REQ];
  logic [NUM_VC-1:0]  vc_busy_q, vc_busy_d;
  logic [NUM_VC-1:0]  out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]  out_flit_q, out_flit_d;
  logic               err_q, err_d;

  logic [NUM_VC-1:0]  free_ready;
  logic [VW-1:0]      alloc_vc;
  logic [NUM_REQ-1:0] hdr, tail, elig, drain, req_ready;
  logic               grant;
  logic [RW-1:0]      grant_idx;
  logic [VW-1:0]      grant_vc;
  logic [FLIT_W-1:0]  grant_flit;

  // Eligibility and the lowest free-and-ready VC for a fresh header.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    free_ready = ~vc_busy_q & bus.out_ready;
    alloc_vc   = '0;
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (free_ready[v]) alloc_vc = VW'(v);
    end
    hdr   = '0;
    tail  = '0;
    elig  = '0;
    drain = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hdr[i]   = bus.req_flit[i*FLIT_W + FLIT_W - 1];
      tail[i]  = bus.req_flit[i*FLIT_W + FLIT_W - 2];
      elig[i]  = bus.req_valid[i] &
                 (bound_q[i] ? bus.out_ready[req_vc_q[i]] : (hdr[i] & (|free_ready)));
      drain[i] = bus.req_valid[i] & ~bound_q[i] & ~hdr[i];
    end
  end

  // Round-robin search starting at the pointer.
  always_comb begin
    int p;
    grant     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      p = int'(rr_ptr_q) + k;
      if (p >= NUM_REQ) p = p - NUM_REQ;
      if (!grant && elig[p]) begin
        grant     = 1'b1;
        grant_idx = RW'(p);
      end
    end
    grant_vc   = bound_q[grant_idx] ? req_vc_q[grant_idx] : alloc_vc;
    grant_flit = bus.req_flit[int'(grant_idx)*FLIT_W +: FLIT_W];
    req_ready  = drain;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    bound_d     = bound_q;
    req_vc_d    = req_vc_q;
    vc_busy_d   = vc_busy_q;
    out_valid_d = '0;
    out_flit_d  = out_flit_q;
    err_d       = err_q | (|drain);
    if (grant) begin
      out_valid_d[grant_vc] = 1'b1;
      out_flit_d            = grant_flit;
      // A header inside an open packet is forwarded as body but flagged.
      if (bound_q[grant_idx] && hdr[grant_idx]) err_d = 1'b1;
      if (tail[grant_idx]) begin
        bound_d[grant_idx]  = 1'b0;
        vc_busy_d[grant_vc] = 1'b0;
      end else if (!bound_q[grant_idx]) begin
        bound_d[grant_idx]  = 1'b1;
        req_vc_d[grant_idx] = alloc_vc;
        vc_busy_d[alloc_vc] = 1'b1;
      end
      rr_ptr_d = (grant_idx == RW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      rr_ptr_q    <= '0;
      bound_q     <= '0;
      vc_busy_q   <= '0;
      out_valid_q <= '0;
      out_flit_q  <= '0;
      err_q       <= 1'b0;
      // NOTE: the binding table is tiny and reset so no stale VC index survives a reset.
      for (int i = 0; i < NUM_REQ; i++) req_vc_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      bound_q     <= bound_d;
      vc_busy_q   <= vc_busy_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      err_q       <= err_d;
      for (int i = 0; i < NUM_REQ; i++) req_vc_q[i] <= req_vc_d[i];
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_flit  = out_flit_q;
  assign bus.vc_busy   = vc_busy_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed scoreboard bench for noc_inject_arbiter: expected output flits are
// queued when a grant is predicted and compared one cycle later.
module tb_noc_inject_arbiter;
  localparam int NR = 4;
  localparam int NV = 4;
  localparam int FW = 34;

  typedef struct packed {
    logic [NV-1:0] vld;
    logic [FW-1:0] flit;
  } exp_t;

  logic noc_clk = 1'b0;
  logic noc_rst;
  always #5 noc_clk = ~noc_clk;

  noc_inject_arbiter_if #(.NUM_REQ(NR), .NUM_VC(NV), .FLIT_W(FW)) bus ();

  noc_inject_arbiter #(.NUM_REQ(NR), .NUM_VC(NV), .FLIT_W(FW)) dut (
    .noc_clk (noc_clk),
    .noc_rst (noc_rst),
    .bus     (bus)
  );

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [NR-1:0] vld;
  logic [FW-1:0] fl [NR];
  int            sent [NR];
  logic [FW-1:0] last_flit;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic h, input logic t, input int p);
    return {h, t, 32'(p)};
  endfunction

  task automatic apply();
    bus.req_valid = vld;
    for (int i = 0; i < NR; i++) bus.req_flit[i*FW +: FW] = fl[i];
  endtask

  // One clock: check req_ready, predict the grant (g<0 means none), check outputs after the edge.
  task automatic cyc(input string tag, input logic [NR-1:0] exp_rdy, input int g, input int vc);
    exp_t e;
    apply();
    #1;
    check({tag, ".req_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      e.vld  = NV'(1) << vc;
      e.flit = fl[g];
      exp_q.push_back(e);
    end
    @(posedge noc_clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(e.vld));
      check({tag, ".out_flit"}, 64'(bus.out_flit), 64'(e.flit));
    end else begin
      check({tag, ".out_valid_idle"}, 64'(bus.out_valid), 64'(0));
    end
  endtask

  task automatic do_reset(input string tag);
    noc_rst = 1'b1;
    apply();
    @(posedge noc_clk);
    #1;
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, ".out_flit"}, 64'(bus.out_flit), 64'(0));
    check({tag, ".vc_busy"}, 64'(bus.vc_busy), 64'(0));
    check({tag, ".err"}, 64'(bus.err), 64'(0));
    noc_rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    noc_rst = 1'b1;
    vld = '0;
    for (int i = 0; i < NR; i++) fl[i] = '0;
    bus.out_ready = '1;
    apply();
    do_reset("reset");

    // Single packet from req0 on VC0. Pointer 0 -> 1 after each grant.
    vld = 4'b0001;
    fl[0] = mk(1'b1, 1'b0, 32'h100);
    cyc("sp_hdr", 4'b0001, 0, 0);
    check("sp_busy_hdr", 64'(bus.vc_busy), 64'(4'b0001));
    fl[0] = mk(1'b0, 1'b0, 32'h101);
    cyc("sp_body", 4'b0001, 0, 0);
    check("sp_busy_body", 64'(bus.vc_busy), 64'(4'b0001));
    fl[0] = mk(1'b0, 1'b1, 32'h102);
    last_flit = fl[0];
    cyc("sp_tail", 4'b0001, 0, 0);
    check("sp_busy_tail", 64'(bus.vc_busy), 64'(0));
    vld = '0;
    cyc("sp_idle", 4'b0000, -1, 0);
    check("sp_flit_hold", 64'(bus.out_flit), 64'(last_flit));
    check("sp_err", 64'(bus.err), 64'(0));

    // Round-robin: reset the pointer, four 4-flit packets interleave 0,1,2,3.
    do_reset("rr_reset");
    for (int i = 0; i < NR; i++) sent[i] = 0;
    for (int c = 0; c < 16; c++) begin
      int g;
      g = c % NR;
      for (int i = 0; i < NR; i++) begin
        vld[i] = (sent[i] < 4);
        fl[i]  = mk(sent[i] == 0, sent[i] == 3, i*16 + sent[i]);
      end
      cyc("rr", NR'(1) << g, g, g);
      sent[g]++;
      if (c == 3) check("rr_busy_all", 64'(bus.vc_busy), 64'(4'b1111));
    end
    check("rr_busy_done", 64'(bus.vc_busy), 64'(0));
    vld = '0;

    // Backpressure on VC0 while req1 keeps using VC1. Pointer starts at 0.
    vld = 4'b0011;
    fl[0] = mk(1'b1, 1'b0, 32'h200);
    fl[1] = mk(1'b1, 1'b0, 32'h300);
    cyc("bp_h0", 4'b0001, 0, 0);
    fl[0] = mk(1'b0, 1'b0, 32'h201);
    cyc("bp_h1", 4'b0010, 1, 1);
    bus.out_ready = 4'b1110;
    for (int c = 0; c < 5; c++) begin
      fl[1] = mk(1'b0, 1'b0, 32'h310 + c);
      cyc("bp_stall", 4'b0010, 1, 1);
    end
    bus.out_ready = 4'b1111;
    cyc("bp_resume", 4'b0001, 0, 0);
    fl[1] = mk(1'b0, 1'b0, 32'h320);
    cyc("bp_r1", 4'b0010, 1, 1);
    fl[0] = mk(1'b0, 1'b1, 32'h202);
    fl[1] = mk(1'b0, 1'b1, 32'h321);
    cyc("bp_t0", 4'b0001, 0, 0);
    vld = 4'b0010;
    cyc("bp_t1", 4'b0010, 1, 1);
    check("bp_busy", 64'(bus.vc_busy), 64'(0));

    // No free VC is ready: header waits. Pointer is 2.
    bus.out_ready = 4'b0000;
    vld = 4'b0001;
    fl[0] = mk(1'b1, 1'b0, 32'h400);
    cyc("none_ready", 4'b0000, -1, 0);

    // VC exhaustion: only VC0/VC1 usable; req2 waits for req0's tail.
    bus.out_ready = 4'b0011;
    vld = 4'b0011;
    fl[1] = mk(1'b1, 1'b0, 32'h500);
    cyc("ex_h0", 4'b0001, 0, 0);
    fl[0] = mk(1'b0, 1'b0, 32'h401);
    cyc("ex_h1", 4'b0010, 1, 1);
    vld = 4'b0111;
    fl[1] = mk(1'b0, 1'b0, 32'h501);
    fl[2] = mk(1'b1, 1'b0, 32'h600);
    cyc("ex_b0", 4'b0001, 0, 0);
    cyc("ex_b1", 4'b0010, 1, 1);
    fl[0] = mk(1'b0, 1'b1, 32'h402);
    cyc("ex_t0", 4'b0001, 0, 0);
    vld = 4'b0110;
    fl[1] = mk(1'b0, 1'b0, 32'h502);
    cyc("ex_b1b", 4'b0010, 1, 1);
    cyc("ex_h2", 4'b0100, 2, 0);
    check("ex_busy", 64'(bus.vc_busy), 64'(4'b0011));
    fl[1] = mk(1'b0, 1'b1, 32'h503);
    fl[2] = mk(1'b0, 1'b1, 32'h601);
    cyc("ex_t1", 4'b0010, 1, 1);
    vld = 4'b0100;
    cyc("ex_t2", 4'b0100, 2, 0);
    check("ex_busy_done", 64'(bus.vc_busy), 64'(0));
    bus.out_ready = 4'b1111;

    // Single-flit packet from req3. Pointer is 3.
    vld = 4'b1000;
    fl[3] = mk(1'b1, 1'b1, 32'h700);
    cyc("sf", 4'b1000, 3, 0);
    check("sf_busy", 64'(bus.vc_busy), 64'(0));
    vld = '0;
    cyc("sf_idle", 4'b0000, -1, 0);

    // Body flit from unbound req1 is drained and flags err. Pointer is 0.
    vld = 4'b0010;
    fl[1] = mk(1'b0, 1'b0, 32'h800);
    cyc("drain", 4'b0010, -1, 0);
    check("drain_err", 64'(bus.err), 64'(1));
    vld = '0;
    cyc("drain_idle", 4'b0000, -1, 0);
    check("err_sticky", 64'(bus.err), 64'(1));

    // Reset in the middle of a packet, then the orphaned body is drained.
    vld = 4'b0001;
    fl[0] = mk(1'b1, 1'b0, 32'h900);
    cyc("mid_hdr", 4'b0001, 0, 0);
    fl[0] = mk(1'b0, 1'b0, 32'h901);
    do_reset("mid_reset");
    cyc("mid_orphan", 4'b0001, -1, 0);
    check("mid_orphan_err", 64'(bus.err), 64'(1));
    check("mid_orphan_busy", 64'(bus.vc_busy), 64'(0));
    vld = '0;
    do_reset("final_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
